// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint slot allocator/recovery controller for the rename stage.
// Optional macro CKPT_STATS_EN adds saturating mispredict/full-stall counters.

module branch_ckpt_ctrl_chk #(
  parameter int NUM_SLOTS = 8,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_gnt,
  input  logic [TAG_W-1:0]     alloc_tag,
  input  logic [NUM_SLOTS-1:0] valid,
  input  logic [TAG_W-1:0]     tags [NUM_SLOTS],
  input  logic [NUM_SLOTS-1:0] match_vec
);
  logic w_dup;

  // Detect an allocation whose tag is already held by a live slot
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid[i] && (tags[i] == alloc_tag)) begin
        w_dup = 1'b1;
      end else begin
        w_dup = w_dup;
      end
    end
  end

  // Protocol checks sampled on each clock edge outside reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc_gnt) begin
        assert (!w_dup) else $error("branch_ckpt_ctrl: allocated tag %0d is already live", alloc_tag);
      end
      assert ($onehot0(match_vec)) else $error("branch_ckpt_ctrl: resolve tag hit more than one slot");
    end
  end
endmodule

module branch_ckpt_ctrl #(
  parameter int NUM_SLOTS = 8,
  parameter int TAG_W     = 5,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req,
  input  logic [TAG_W-1:0]     alloc_tag,
  output logic                 alloc_gnt,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic                 resolve_valid,
  input  logic [TAG_W-1:0]     resolve_tag,
  input  logic                 resolve_mispredict,
  input  logic [TAG_W-1:0]     rob_head,
  output logic                 restore_valid,
  output logic [IDX_W-1:0]     restore_idx,
  output logic [NUM_SLOTS-1:0] live_mask,
  output logic [IDX_W:0]       count,
  output logic                 full,
  output logic                 resolve_miss
`ifdef CKPT_STATS_EN
  ,
  output logic [15:0]          stat_mispredicts,
  output logic [15:0]          stat_full_stalls
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(NUM_SLOTS);

  function automatic logic [IDX_W:0] count_ones(input logic [NUM_SLOTS-1:0] v);
    logic [IDX_W:0] c;
    c = {(IDX_W+1){1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_SLOTS-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag [NUM_SLOTS];
  logic                 r_restore_valid;
  logic [IDX_W-1:0]     r_restore_idx;
  logic [IDX_W:0]       r_count;
  logic                 r_full;
  logic                 r_resolve_miss;

  logic [IDX_W-1:0]     w_free_idx;
  logic [NUM_SLOTS-1:0] w_match_vec;
  logic [IDX_W-1:0]     w_match_idx;
  logic                 w_any_match;
  logic                 w_mis_hit;
  logic                 w_ok_hit;
  logic                 w_miss;
  logic [TAG_W-1:0]     w_res_age;
  logic [NUM_SLOTS-1:0] w_clear;
  logic [NUM_SLOTS-1:0] w_set;
  logic [NUM_SLOTS-1:0] w_valid_nxt;
  logic [IDX_W:0]       w_count_nxt;
  logic                 w_gnt;

  // Lowest-index free slot, judged on registered valid bits only
  always_comb begin
    w_free_idx = {IDX_W{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
      end else begin
        w_free_idx = w_free_idx;
      end
    end
  end

  // Resolve tag lookup across live slots
  always_comb begin
    w_match_vec = {NUM_SLOTS{1'b0}};
    w_match_idx = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_match_vec[i] = r_valid[i] && (r_tag[i] == resolve_tag);
      if (w_match_vec[i]) begin
        w_match_idx = IDX_W'(i);
      end else begin
        w_match_idx = w_match_idx;
      end
    end
  end

  assign w_any_match = |w_match_vec;
  assign w_mis_hit   = resolve_valid && resolve_mispredict && w_any_match;
  assign w_ok_hit    = resolve_valid && !resolve_mispredict && w_any_match;
  assign w_miss      = resolve_valid && !w_any_match;
  assign w_res_age   = resolve_tag - rob_head;

  // Slots freed this edge: the hit slot, plus every younger live slot on a mispredict
  always_comb begin
    logic [TAG_W-1:0] v_age;
    v_age   = {TAG_W{1'b0}};
    w_clear = {NUM_SLOTS{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      v_age = r_tag[i] - rob_head;
      if (w_mis_hit) begin
        w_clear[i] = w_match_vec[i] || (r_valid[i] && (v_age > w_res_age));
      end else if (w_ok_hit) begin
        w_clear[i] = w_match_vec[i];
      end else begin
        w_clear[i] = 1'b0;
      end
    end
  end

  // One-hot set mask for the granted slot
  always_comb begin
    w_set = {NUM_SLOTS{1'b0}};
    if (w_gnt) begin
      w_set[w_free_idx] = 1'b1;
    end else begin
      w_set = {NUM_SLOTS{1'b0}};
    end
  end

  assign w_valid_nxt = (r_valid & ~w_clear) | w_set;
  assign w_count_nxt = count_ones(w_valid_nxt);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_mis_hit) begin
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: grants only in IDLE, never alongside any mispredict resolve
  always_comb begin
    w_gnt = 1'b0;
    case (r_state)
      ST_IDLE:    w_gnt = alloc_req && !r_full && !(resolve_valid && resolve_mispredict);
      ST_RECOVER: w_gnt = 1'b0;
      default:    w_gnt = 1'b0;
    endcase
  end

  assign alloc_gnt = w_gnt;
  assign alloc_idx = w_free_idx;

  // Slot state and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid         <= {NUM_SLOTS{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_tag[i] <= {TAG_W{1'b0}};
      end
      r_restore_valid <= 1'b0;
      r_restore_idx   <= {IDX_W{1'b0}};
      r_count         <= {(IDX_W+1){1'b0}};
      r_full          <= 1'b0;
      r_resolve_miss  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_set[i]) begin
          r_tag[i] <= alloc_tag;
        end
      end
      r_restore_valid <= w_mis_hit;
      if (w_mis_hit) begin
        r_restore_idx <= w_match_idx;
      end
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == FULL_CNT);
      r_resolve_miss <= w_miss;
    end
  end

  assign restore_valid = r_restore_valid;
  assign restore_idx   = r_restore_idx;
  assign live_mask     = r_valid;
  assign count         = r_count;
  assign full          = r_full;
  assign resolve_miss  = r_resolve_miss;

`ifdef CKPT_STATS_EN
  logic [15:0] r_stat_mis;
  logic [15:0] r_stat_full;

  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_mis  <= 16'd0;
      r_stat_full <= 16'd0;
    end else begin
      if (w_mis_hit && (r_stat_mis != 16'hFFFF)) begin
        r_stat_mis <= r_stat_mis + 16'd1;
      end
      if (alloc_req && r_full && (r_stat_full != 16'hFFFF)) begin
        r_stat_full <= r_stat_full + 16'd1;
      end
    end
  end

  assign stat_mispredicts = r_stat_mis;
  assign stat_full_stalls = r_stat_full;
`endif

  branch_ckpt_ctrl_chk #(
    .NUM_SLOTS (NUM_SLOTS),
    .TAG_W     (TAG_W)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .alloc_gnt (w_gnt),
    .alloc_tag (alloc_tag),
    .valid     (r_valid),
    .tags      (r_tag),
    .match_vec (w_match_vec)
  );

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Self-checking bench for branch_ckpt_ctrl: directed plan steps plus random traffic
// compared against a slot-level behavioural model.
module tb_branch_ckpt_ctrl;
  localparam int NUM     = 8;
  localparam int TAG_MOD = 32;

  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic [4:0] alloc_tag;
  logic       alloc_gnt;
  logic [2:0] alloc_idx;
  logic       resolve_valid;
  logic [4:0] resolve_tag;
  logic       resolve_mispredict;
  logic [4:0] rob_head;
  logic       restore_valid;
  logic [2:0] restore_idx;
  logic [7:0] live_mask;
  logic [3:0] count;
  logic       full;
  logic       resolve_miss;
`ifdef CKPT_STATS_EN
  logic [15:0] stat_mispredicts;
  logic [15:0] stat_full_stalls;
  int          m_smis;
  int          m_sfull;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit m_valid [NUM];
  int m_tag   [NUM];
  bit m_rec;
  bit m_rv;
  bit m_miss;
  int m_ridx;

  logic       last_gnt;
  logic [2:0] last_idx;

  branch_ckpt_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .alloc_req          (alloc_req),
    .alloc_tag          (alloc_tag),
    .alloc_gnt          (alloc_gnt),
    .alloc_idx          (alloc_idx),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .rob_head           (rob_head),
    .restore_valid      (restore_valid),
    .restore_idx        (restore_idx),
    .live_mask          (live_mask),
    .count              (count),
    .full               (full),
    .resolve_miss       (resolve_miss)
`ifdef CKPT_STATS_EN
    ,
    .stat_mispredicts   (stat_mispredicts),
    .stat_full_stalls   (stat_full_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int age(input int t, input int h);
    return ((t - h) % TAG_MOD + TAG_MOD) % TAG_MOD;
  endfunction

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < NUM; i++) n += m_valid[i];
    return n;
  endfunction

  function automatic bit is_live(input int t);
    for (int i = 0; i < NUM; i++) if (m_valid[i] && m_tag[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] r = 8'd0;
    for (int i = 0; i < NUM; i++) r[i] = m_valid[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
    m_rec = 1'b0; m_rv = 1'b0; m_miss = 1'b0; m_ridx = 0;
`ifdef CKPT_STATS_EN
    m_smis = 0; m_sfull = 0;
`endif
  endtask

  task automatic drive(input bit req, input int atag, input bit rv, input int rtag, input bit rm, input int head);
    alloc_req = req; alloc_tag = atag[4:0];
    resolve_valid = rv; resolve_tag = rtag[4:0]; resolve_mispredict = rm;
    rob_head = head[4:0];
  endtask

  task automatic check_regs();
    chk("live_mask", live_mask, m_mask());
    chk("count", count, live_count());
    chk("full", full, live_count() == NUM);
    chk("restore_valid", restore_valid, m_rv);
    if (m_rv) chk("restore_idx", restore_idx, m_ridx);
    chk("resolve_miss", resolve_miss, m_miss);
`ifdef CKPT_STATS_EN
    chk("stat_mispredicts", stat_mispredicts, m_smis);
    chk("stat_full_stalls", stat_full_stalls, m_sfull);
`endif
  endtask

  // One clock: check combinational grant, advance model at the edge, check registers
  task automatic cycle();
    bit g;
    int idx;
    int m;
    bit mis;
    int ra;
    #1;
    g   = alloc_req && (live_count() != NUM) && !m_rec && !(resolve_valid && resolve_mispredict);
    idx = 0;
    for (int i = NUM - 1; i >= 0; i--) if (!m_valid[i]) idx = i;
    last_gnt = alloc_gnt;
    last_idx = alloc_idx;
    chk("alloc_gnt", alloc_gnt, g);
    if (g) chk("alloc_idx", alloc_idx, idx);
    @(posedge clk);
`ifdef CKPT_STATS_EN
    if (alloc_req && live_count() == NUM && m_sfull < 65535) m_sfull++;
`endif
    m = -1;
    mis = 1'b0;
    for (int i = 0; i < NUM; i++) if (m_valid[i] && m_tag[i] == int'(resolve_tag)) m = i;
    m_miss = resolve_valid && (m < 0);
    if (resolve_valid && m >= 0) begin
      if (resolve_mispredict) begin
        ra = age(resolve_tag, rob_head);
        for (int i = 0; i < NUM; i++)
          if (m_valid[i] && age(m_tag[i], rob_head) > ra) m_valid[i] = 1'b0;
        m_valid[m] = 1'b0;
        mis = 1'b1;
        m_ridx = m;
      end else begin
        m_valid[m] = 1'b0;
      end
    end
    if (g) begin m_valid[idx] = 1'b1; m_tag[idx] = alloc_tag; end
    m_rv  = mis;
    m_rec = !m_rec && mis;
`ifdef CKPT_STATS_EN
    if (mis && m_smis < 65535) m_smis++;
`endif
    #1;
    check_regs();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_restore_valid", restore_valid, 1'b0);
    chk("rst_restore_idx", restore_idx, 3'd0);
    chk("rst_live_mask", live_mask, 8'd0);
    chk("rst_count", count, 4'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_resolve_miss", resolve_miss, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int t;
    int lv[$];
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Plan 1: three consecutive grants
    do_reset();
    drive(1, 3, 0, 0, 0, 0); cycle(); chk("t1_idx0", last_idx, 3'd0);
    drive(1, 4, 0, 0, 0, 0); cycle(); chk("t1_idx1", last_idx, 3'd1);
    drive(1, 5, 0, 0, 0, 0); cycle(); chk("t1_idx2", last_idx, 3'd2);
    chk("t1_count", count, 4'd3);
    chk("t1_mask", live_mask, 8'b00000111);

    // Plan 2: fill, stall, free one, retry
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1, i, 0, 0, 0, 0); cycle(); end
    chk("t2_full", full, 1'b1);
    drive(1, 8, 0, 0, 0, 0); cycle(); chk("t2_stall", last_gnt, 1'b0);
    drive(1, 8, 1, 2, 0, 0); cycle(); chk("t2_stall_same", last_gnt, 1'b0);
    chk("t2_notfull", full, 1'b0);
    drive(1, 8, 0, 0, 0, 0); cycle();
    chk("t2_retry_gnt", last_gnt, 1'b1);
    chk("t2_retry_idx", last_idx, 3'd2);

    // Plan 3: mispredict squashes younger slots
    do_reset();
    drive(1, 1, 0, 0, 0, 0); cycle();
    drive(1, 4, 0, 0, 0, 0); cycle();
    drive(1, 6, 0, 0, 0, 0); cycle();
    drive(1, 9, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 4, 1, 0); cycle();
    chk("t3_rv", restore_valid, 1'b1);
    chk("t3_ridx", restore_idx, 3'd1);
    chk("t3_mask", live_mask, 8'b00000001);
    chk("t3_count", count, 4'd1);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("t3_rv_drop", restore_valid, 1'b0);

    // Plan 4: age wrap-around
    do_reset();
    drive(1, 30, 0, 0, 0, 30); cycle();
    drive(1, 31, 0, 0, 0, 30); cycle();
    drive(1, 1, 0, 0, 0, 30); cycle();
    drive(0, 0, 1, 31, 1, 30); cycle();
    chk("t4_mask", live_mask, 8'b00000001);
    chk("t4_ridx", restore_idx, 3'd1);

    // Plan 5: grant blocked by mispredict and during RECOVER
    do_reset();
    drive(1, 8, 0, 0, 0, 0); cycle();
    drive(1, 10, 0, 0, 0, 0); cycle();
    drive(1, 11, 0, 0, 0, 0); cycle();
    drive(1, 12, 1, 10, 1, 0); cycle(); chk("t5_gnt_mis", last_gnt, 1'b0);
    chk("t5_rv", restore_valid, 1'b1);
    drive(1, 12, 0, 0, 0, 0); cycle(); chk("t5_gnt_rec", last_gnt, 1'b0);
    drive(1, 12, 0, 0, 0, 0); cycle(); chk("t5_gnt_after", last_gnt, 1'b1);
    chk("t5_idx_after", last_idx, 3'd1);

    // Plan 6: unmatched resolve pulses resolve_miss only
    drive(0, 0, 1, 20, 1, 0); cycle();
    chk("t6_miss", resolve_miss, 1'b1);
    chk("t6_mask", live_mask, 8'b00000011);
    chk("t6_norestore", restore_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("t6_miss_drop", resolve_miss, 1'b0);

    // Reset during RECOVER aborts recovery
    drive(0, 0, 1, 8, 1, 0); cycle();
    chk("t7_rv", restore_valid, 1'b1);
    do_reset();
    drive(1, 7, 0, 0, 0, 0); cycle(); chk("t7_gnt", last_gnt, 1'b1);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      lv.delete();
      for (int i = 0; i < NUM; i++) if (m_valid[i]) lv.push_back(m_tag[i]);
      t = $urandom_range(0, 31);
      while (is_live(t)) t = (t + 1) % TAG_MOD;
      alloc_req = ($urandom_range(0, 3) != 0);
      alloc_tag = t[4:0];
      resolve_valid = ($urandom_range(0, 1) == 1);
      resolve_mispredict = ($urandom_range(0, 4) == 0);
      if (lv.size() > 0 && $urandom_range(0, 3) != 0)
        resolve_tag = lv[$urandom_range(0, lv.size() - 1)];
      else
        resolve_tag = $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rob_head = $urandom_range(0, 31);
      cycle();
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
